// File: rtl/instruction_fetch.sv
// Fetch stage: samples the PC, issues one word-aligned imem request at a time and
// hands the returned instruction to the decoder over a valid/ready handshake.
module instruction_fetch #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_advance,
  input  logic              flush,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fetch_fault,
  output logic [31:0]       fetch_count
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StReq   = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;
  localparam logic [2:0] StFault = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              req_fresh_q, req_fresh_d;
  logic              req_gap_q, req_gap_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [31:0]       count_q, count_d;

  logic              req_live;
  logic              misaligned;
  logic              req_accept;
  logic [ADDR_W-1:0] pc_aligned;

  // The entry cycle of REQ samples pc_in directly so a settled PC is requested without
  // an extra cycle; later cycles replay the captured address.
  assign pc_aligned     = {pc_in[ADDR_W-1:2], 2'b00};
  assign req_live       = (state_q == StReq) && !req_gap_q;
  assign misaligned     = req_fresh_q && (pc_in[1:0] != 2'b00);
  assign imem_req_valid = req_live && !misaligned;
  assign imem_req_addr  = (req_live && req_fresh_q) ? pc_aligned : addr_q;
  assign req_accept     = imem_req_valid && imem_req_ready;

  assign instr_valid = (state_q == StHold);
  assign pc_advance  = instr_valid && instr_ready && !flush;
  assign fetch_fault = (state_q == StFault);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_count = count_q;

  always_comb begin
    state_d     = state_q;
    req_fresh_d = req_fresh_q;
    req_gap_d   = req_gap_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    count_d     = count_q;

    case (state_q)
      StIdle: begin
        state_d     = StReq;
        req_fresh_d = 1'b1;
        req_gap_d   = 1'b0;
      end
      StReq: begin
        if (req_gap_q) begin
          // Dead cycle after a flush; resample the PC next cycle.
          req_gap_d   = 1'b0;
          req_fresh_d = 1'b1;
        end else begin
          if (req_fresh_q) begin
            addr_d = pc_aligned;
          end
          req_fresh_d = 1'b0;
          if (flush) begin
            if (req_accept) begin
              state_d = StDrain;
            end else begin
              req_gap_d   = 1'b1;
              req_fresh_d = 1'b1;
            end
          end else if (misaligned) begin
            state_d = StFault;
          end else if (req_accept) begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (flush) begin
          state_d     = imem_rsp_valid ? StReq : StDrain;
          req_fresh_d = 1'b1;
          req_gap_d   = 1'b0;
        end else if (imem_rsp_valid) begin
          state_d    = StHold;
          instr_d    = imem_rsp_data;
          instr_pc_d = addr_q;
        end
      end
      StHold: begin
        if (flush || instr_ready) begin
          state_d     = StReq;
          req_fresh_d = 1'b1;
          req_gap_d   = 1'b0;
          if (!flush) begin
            count_d = count_q + 32'd1;
          end
        end
      end
      StDrain: begin
        if (imem_rsp_valid) begin
          state_d     = StReq;
          req_fresh_d = 1'b1;
          req_gap_d   = 1'b0;
        end
      end
      StFault: begin
        if (flush) begin
          state_d     = StReq;
          req_fresh_d = 1'b1;
          req_gap_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      req_fresh_q <= 1'b0;
      req_gap_q   <= 1'b0;
      addr_q      <= '0;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_fresh_q <= req_fresh_d;
      req_gap_q   <= req_gap_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; expected requests and instructions are queued by
// the stimulus and checked by a monitor whenever the DUT completes a handshake.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_instr_q[$];

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_in          (pc_in),
    .pc_advance     (pc_advance),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_fault    (fetch_fault),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc_advance"}, pc_advance, 0);
    chk({tag, "_req_valid"}, imem_req_valid, 0);
    chk({tag, "_req_addr"}, imem_req_addr, 0);
    chk({tag, "_instr_valid"}, instr_valid, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_instr_pc"}, instr_pc, 0);
    chk({tag, "_fault"}, fetch_fault, 0);
    chk({tag, "_count"}, fetch_count, 0);
  endtask

  // Scoreboard monitor: pops an expectation on every completed handshake.
  always @(negedge clk) begin
    if (rst_n && imem_req_valid && imem_req_ready) begin
      if (exp_addr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL req_unexpected: got request addr 0x%0h, expected no request",
                 imem_req_addr);
      end else begin
        chk("req_addr", imem_req_addr, exp_addr_q.pop_front());
      end
    end
    if (rst_n && instr_valid && instr_ready && !flush) begin
      if (exp_instr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL instr_unexpected: got instr 0x%0h pc 0x%0h, expected none",
                 instr, instr_pc);
      end else begin
        chk("instr_and_pc", {instr, instr_pc}, exp_instr_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n          = 1'b0;
    pc_in          = '0;
    flush          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    smp(); chk_reset("rst");

    // Basic fetch: IDLE c0, REQ c1, WAIT c2, HOLD c3.
    cyc(); rst_n = 1'b1; pc_in = 32'h0; imem_req_ready = 1'b1; exp_addr_q.push_back(32'h0);
    smp(); chk("idle_no_req", imem_req_valid, 0);
    cyc(); smp(); chk("c1_req_valid", imem_req_valid, 1); chk("c1_req_addr", imem_req_addr, 0);
    cyc(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h20080005;
    exp_instr_q.push_back({32'h20080005, 32'h0});
    smp(); chk("c2_no_instr", instr_valid, 0);
    cyc(); imem_rsp_valid = 1'b0; instr_ready = 1'b1;
    smp(); chk("c3_valid", instr_valid, 1); chk("c3_instr", instr, 32'h20080005);
    chk("c3_pc", instr_pc, 0); chk("c3_advance", pc_advance, 1);
    cyc(); instr_ready = 1'b0; pc_in = 32'h4; exp_addr_q.push_back(32'h4);
    smp(); chk("count_1", fetch_count, 1); chk("adv_pulse_end", pc_advance, 0);
    chk("valid_drop", instr_valid, 0); chk("bp_req0", imem_req_addr, 32'h4);

    // Request back-pressure: address must not follow a changing pc_in.
    for (int i = 0; i < 3; i++) begin
      cyc(); pc_in = 32'h104;
      smp(); chk("bp_req_valid", imem_req_valid, 1); chk("bp_req_addr", imem_req_addr, 32'h4);
    end
    cyc(); imem_req_ready = 1'b1;
    smp();
    cyc(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h8C090004;
    exp_instr_q.push_back({32'h8C090004, 32'h4});
    smp();
    cyc(); imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      smp(); chk("bp_hold_valid", instr_valid, 1); chk("bp_hold_instr", instr, 32'h8C090004);
      chk("bp_no_adv", pc_advance, 0);
      cyc();
    end
    instr_ready = 1'b1;
    smp(); chk("bp_adv", pc_advance, 1);

    // Flush in WAIT, stale response drained, new PC requested.
    cyc(); instr_ready = 1'b0; pc_in = 32'h8; imem_req_ready = 1'b1; exp_addr_q.push_back(32'h8);
    smp(); chk("count_2", fetch_count, 2);
    cyc(); imem_req_ready = 1'b0; flush = 1'b1;
    smp();
    cyc(); flush = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF; pc_in = 32'h40;
    instr_ready = 1'b1;
    smp(); chk("drain_no_valid", instr_valid, 0); chk("drain_no_req", imem_req_valid, 0);
    cyc(); imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; exp_addr_q.push_back(32'h40);
    smp(); chk("post_drain_no_valid", instr_valid, 0); chk("post_drain_addr", imem_req_addr, 32'h40);
    cyc(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00851020;
    exp_instr_q.push_back({32'h00851020, 32'h40});
    smp();
    cyc(); imem_rsp_valid = 1'b0;
    smp(); chk("flush_recover_adv", pc_advance, 1);

    // Flush coincident with decoder accept in HOLD.
    cyc(); instr_ready = 1'b0; pc_in = 32'h44; imem_req_ready = 1'b1; exp_addr_q.push_back(32'h44);
    smp(); chk("count_3", fetch_count, 3);
    cyc(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h12345678;
    smp();
    cyc(); imem_rsp_valid = 1'b0; flush = 1'b1; instr_ready = 1'b1;
    smp(); chk("hold_flush_valid", instr_valid, 1); chk("hold_flush_no_adv", pc_advance, 0);
    cyc(); flush = 1'b0; instr_ready = 1'b0; imem_req_ready = 1'b1; exp_addr_q.push_back(32'h44);
    smp(); chk("hold_flush_drop", instr_valid, 0); chk("hold_flush_count", fetch_count, 3);
    cyc(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hAAAA0000;
    exp_instr_q.push_back({32'hAAAA0000, 32'h44});
    smp();
    cyc(); imem_rsp_valid = 1'b0; instr_ready = 1'b1;
    smp(); chk("refetch_adv", pc_advance, 1);

    // Misaligned PC faults until flushed.
    cyc(); instr_ready = 1'b0; pc_in = 32'h6; imem_req_ready = 1'b1;
    smp(); chk("count_4", fetch_count, 4); chk("mis_no_req", imem_req_valid, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); smp(); chk("fault_held", fetch_fault, 1); chk("fault_no_req", imem_req_valid, 0);
    end
    cyc(); flush = 1'b1; pc_in = 32'h8;
    smp(); chk("fault_flush_cycle", fetch_fault, 1);
    cyc(); flush = 1'b0; exp_addr_q.push_back(32'h8);
    smp(); chk("fault_cleared", fetch_fault, 0); chk("fault_req_valid", imem_req_valid, 1);
    chk("fault_req_addr", imem_req_addr, 32'h8);

    // Reset during WAIT; a late response after release must be ignored.
    cyc(); imem_req_ready = 1'b0;
    smp(); chk("wait_pre_reset", instr_valid, 0);
    cyc(); rst_n = 1'b0;
    smp(); chk_reset("mid_rst");
    cyc(); rst_n = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBADBAD00; instr_ready = 1'b1;
    smp(); chk("stale_no_valid", instr_valid, 0); chk("stale_no_req", imem_req_valid, 0);
    cyc(); imem_rsp_valid = 1'b0; pc_in = 32'h80; imem_req_ready = 1'b1;
    exp_addr_q.push_back(32'h80);
    smp(); chk("stale_still_no_valid", instr_valid, 0); chk("rst_count", fetch_count, 0);
    chk("post_rst_req", imem_req_valid, 1);
    cyc(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h11112222;
    exp_instr_q.push_back({32'h11112222, 32'h80});
    smp();
    cyc(); imem_rsp_valid = 1'b0;
    smp(); chk("post_rst_adv", pc_advance, 1);
    cyc(); instr_ready = 1'b0;
    smp(); chk("post_rst_count", fetch_count, 1);

    chk("addr_queue_drained", exp_addr_q.size(), 0);
    chk("instr_queue_drained", exp_instr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
